// File: rtl/mc_pkg.sv
// Shared types and constants for the multicycle MIPS main controller:
// FSM states, ALU-decoder operation classes, opcode/funct fields and ALU codes.
package mc_pkg;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    ALUWB   = 4'd7,
    BEQ     = 4'd8,
    IMMEX   = 4'd9,
    IMMWB   = 4'd10,
    JUMP    = 4'd11
  } mc_state_e;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10,
    ALUOP_IMM   = 2'b11
  } aluop_e;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'd0;
  localparam logic [2:0] ALU_OR  = 3'd1;
  localparam logic [2:0] ALU_ADD = 3'd2;
  localparam logic [2:0] ALU_SUB = 3'd6;
  localparam logic [2:0] ALU_SLT = 3'd7;

endpackage

// File: rtl/mc_controller_if.sv
// Controller <-> datapath bundle: instruction fields and zero flag in, control
// strobes/selects out, plus the FSM state as a debug observation point.
interface mc_controller_if;
  import mc_pkg::*;

  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       pcen;
  logic       iord;
  logic       memwrite;
  logic       irwrite;
  logic       regdst;
  logic       memtoreg;
  logic       regwrite;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic       extop;
  logic [1:0] pcsrc;
  logic [2:0] alucontrol;
  logic       illegal;
  mc_state_e  state;

  // Controller side.
  modport master (
    input  op, funct, zero,
    output pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
           alusrca, alusrcb, extop, pcsrc, alucontrol, illegal, state
  );

  // Datapath side.
  modport slave (
    output op, funct, zero,
    input  pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
           alusrca, alusrcb, extop, pcsrc, alucontrol, illegal, state
  );

endinterface

// File: rtl/mc_controller_alu_dec.sv
// ALU decoder: maps the FSM's operation class plus op/funct to the 3-bit ALU
// code, and flags whether funct names a supported R-type operation.
module alu_dec
  import mc_pkg::*;
(
  input  aluop_e     aluop_i,
  input  logic [5:0] op_i,
  input  logic [5:0] funct_i,
  output logic [2:0] alucontrol_o,
  output logic       funct_valid_o
);

  logic [2:0] funct_alu;

  always_comb begin
    funct_alu     = ALU_ADD;
    funct_valid_o = 1'b1;
    case (funct_i)
      F_ADD:   funct_alu = ALU_ADD;
      F_SUB:   funct_alu = ALU_SUB;
      F_AND:   funct_alu = ALU_AND;
      F_OR:    funct_alu = ALU_OR;
      F_SLT:   funct_alu = ALU_SLT;
      default: funct_valid_o = 1'b0;
    endcase
  end

  always_comb begin
    alucontrol_o = ALU_ADD;
    case (aluop_i)
      ALUOP_ADD:   alucontrol_o = ALU_ADD;
      ALUOP_SUB:   alucontrol_o = ALU_SUB;
      ALUOP_FUNCT: alucontrol_o = funct_alu;
      ALUOP_IMM: begin
        // addi falls through to ADD; only the logical immediates change the op.
        if (op_i == OP_ANDI)     alucontrol_o = ALU_AND;
        else if (op_i == OP_ORI) alucontrol_o = ALU_OR;
      end
      default:     alucontrol_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Moore main control FSM for the multicycle MIPS datapath. Op/funct are decoded
// combinationally every cycle; they stay stable because IR loads only in FETCH.
module mc_controller
  import mc_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  mc_controller_if.master bus
);

  mc_state_e state_q, state_d;
  aluop_e    aluop;
  logic      pcwrite;
  logic      branch;
  logic      funct_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  alu_dec u_alu_dec (
    .aluop_i       (aluop),
    .op_i          (bus.op),
    .funct_i       (bus.funct),
    .alucontrol_o  (bus.alucontrol),
    .funct_valid_o (funct_valid)
  );

  always_comb begin
    state_d      = FETCH;
    aluop        = ALUOP_ADD;
    pcwrite      = 1'b0;
    branch       = 1'b0;
    bus.iord     = 1'b0;
    bus.memwrite = 1'b0;
    bus.irwrite  = 1'b0;
    bus.regdst   = 1'b0;
    bus.memtoreg = 1'b0;
    bus.regwrite = 1'b0;
    bus.alusrca  = 1'b0;
    bus.alusrcb  = 2'b00;
    bus.extop    = 1'b0;
    bus.pcsrc    = 2'b00;
    bus.illegal  = 1'b0;
    case (state_q)
      FETCH: begin
        bus.alusrcb = 2'b01;
        bus.irwrite = 1'b1;
        pcwrite     = 1'b1;
        state_d     = DECODE;
      end
      DECODE: begin
        // Branch target is precomputed into ALUOut here, whatever the op.
        bus.alusrcb = 2'b11;
        case (bus.op)
          OP_LW, OP_SW:               state_d = MEMADR;
          OP_RTYPE: begin
            if (funct_valid) state_d = RTYPEEX;
            else             bus.illegal = 1'b1;
          end
          OP_BEQ:                     state_d = BEQ;
          OP_ADDI, OP_ANDI, OP_ORI:   state_d = IMMEX;
          OP_J:                       state_d = JUMP;
          default:                    bus.illegal = 1'b1;
        endcase
      end
      MEMADR: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = 2'b10;
        state_d     = (bus.op == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        bus.iord = 1'b1;
        state_d  = MEMWB;
      end
      MEMWB: begin
        bus.memtoreg = 1'b1;
        bus.regwrite = 1'b1;
      end
      MEMWR: begin
        bus.iord     = 1'b1;
        bus.memwrite = 1'b1;
      end
      RTYPEEX: begin
        bus.alusrca = 1'b1;
        aluop       = ALUOP_FUNCT;
        state_d     = ALUWB;
      end
      ALUWB: begin
        bus.regdst   = 1'b1;
        bus.regwrite = 1'b1;
      end
      BEQ: begin
        bus.alusrca = 1'b1;
        aluop       = ALUOP_SUB;
        bus.pcsrc   = 2'b01;
        branch      = 1'b1;
      end
      IMMEX: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = 2'b10;
        aluop       = ALUOP_IMM;
        bus.extop   = (bus.op == OP_ANDI) || (bus.op == OP_ORI);
        state_d     = IMMWB;
      end
      IMMWB: begin
        bus.regwrite = 1'b1;
      end
      JUMP: begin
        bus.pcsrc = 2'b10;
        pcwrite   = 1'b1;
      end
      default: state_d = FETCH;
    endcase
  end

  assign bus.pcen  = pcwrite | (branch & bus.zero);
  assign bus.state = state_q;

endmodule
